// File: rtl/lock_pkg.sv
// Shared constants for the electronic lock controller: state encoding,
// special key codes and the timer width helper.
package lock_pkg;

   localparam logic [1:0] ST_LOCKED = 2'd0;
   localparam logic [1:0] ST_OPEN   = 2'd1;
   localparam logic [1:0] ST_ALARM  = 2'd2;

   localparam logic [3:0] KEY_STAR  = 4'hA;
   localparam logic [3:0] KEY_HASH  = 4'hB;

   // Bits needed to count 0 .. max(a,b)-1.
   function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector on keyenbl: one kev pulse per press plus the keycode
// captured on the edge cycle. Resets "high" so a held key needs a new press.
module key_edge (
   input  logic       ck,
   input  logic       resetn,
   input  logic       keyenbl,
   input  logic [3:0] keycode,
   output logic       kev,
   output logic [3:0] key
);

   logic enbl_q;
   logic rise_c;

   assign rise_c = keyenbl & ~enbl_q;

   always_ff @(posedge ck or negedge resetn) begin
      if (!resetn) begin
         enbl_q <= 1'b1;
         kev    <= 1'b0;
         key    <= 4'h0;
      end else begin
         enbl_q <= keyenbl;
         kev    <= rise_c;
         if (rise_c) key <= keycode;
      end
   end

endmodule

// File: rtl/lock_ctrl.sv
// Keypad lock controller: code entry, compare, auto-relock and alarm.
// Define CODE_CHANGE_EN to allow reprogramming the code with '#' while open.
module lock_ctrl
   import lock_pkg::*;
#(
   parameter int unsigned DIGITS      = 4,
   parameter logic [DIGITS*4-1:0] INIT_CODE = 16'h1234,
   parameter int unsigned OPEN_TICKS  = 160,
   parameter int unsigned MAX_FAIL    = 3,
   parameter int unsigned ALARM_TICKS = 320
) (
   input  logic                ck,
   input  logic                resetn,
   input  logic                tick,
   input  logic [3:0]          keycode,
   input  logic                keyenbl,
   output logic [DIGITS*4-1:0] sftreg,
   output logic [3:0]          ndig,
   output logic                unlock,
   output logic                alarm,
   output logic [1:0]          failcnt
);

   localparam int unsigned W  = DIGITS * 4;
   localparam int unsigned TW = tmr_width(OPEN_TICKS, ALARM_TICKS);

   logic          kev;
   logic [3:0]    key;
   logic [1:0]    state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [W-1:0]  sftreg_n, shifted;
   logic [W-1:0]  code;
   logic [3:0]    ndig_n, ndig_inc;
   logic [1:0]    failcnt_n;
   logic          is_dig, is_star, is_hash, full, match, fail_max;
   logic          open_exp, alarm_exp;

   key_edge u_key_edge (
      .ck      (ck),
      .resetn  (resetn),
      .keyenbl (keyenbl),
      .keycode (keycode),
      .kev     (kev),
      .key     (key)
   );

`ifdef CODE_CHANGE_EN
   logic [W-1:0] code_n;
   always_ff @(posedge ck or negedge resetn) begin
      if (!resetn) code <= INIT_CODE;
      else         code <= code_n;
   end
`else
   assign code = INIT_CODE;
`endif

   assign is_dig    = kev && (key <= 4'd9);
   assign is_star   = kev && (key == KEY_STAR);
   assign is_hash   = kev && (key == KEY_HASH);
   assign full      = (ndig == 4'(DIGITS));
   assign match     = full && (sftreg == code);
   assign fail_max  = (32'(failcnt) + 32'd1) >= 32'(MAX_FAIL);
   assign open_exp  = (state == ST_OPEN)  && tick && (timer == TW'(OPEN_TICKS - 1));
   assign alarm_exp = (state == ST_ALARM) && tick && (timer == TW'(ALARM_TICKS - 1));
   assign shifted   = W'({sftreg, key});
   assign ndig_inc  = full ? ndig : ndig + 4'd1;

   // State register and all datapath/output registers.
   always_ff @(posedge ck or negedge resetn) begin
      if (!resetn) begin
         state   <= ST_LOCKED;
         timer   <= '0;
         sftreg  <= '0;
         ndig    <= 4'd0;
         failcnt <= 2'd0;
         unlock  <= 1'b0;
         alarm   <= 1'b0;
      end else begin
         state   <= state_n;
         timer   <= timer_n;
         sftreg  <= sftreg_n;
         ndig    <= ndig_n;
         failcnt <= failcnt_n;
         unlock  <= (state_n == ST_OPEN);
         alarm   <= (state_n == ST_ALARM);
      end
   end

   // Next-state logic; an expiring timer takes precedence over any key.
   always_comb begin
      state_n = state;
      case (state)
         ST_LOCKED: begin
            if (is_hash) begin
               if (match)         state_n = ST_OPEN;
               else if (fail_max) state_n = ST_ALARM;
            end
         end
         ST_OPEN:  if (open_exp || is_star) state_n = ST_LOCKED;
         ST_ALARM: if (alarm_exp)           state_n = ST_LOCKED;
         default:  state_n = ST_LOCKED;
      endcase
   end

   // Datapath next values: entry register, digit count, fail count, timer.
   always_comb begin
      sftreg_n  = sftreg;
      ndig_n    = ndig;
      failcnt_n = failcnt;
      timer_n   = timer;
`ifdef CODE_CHANGE_EN
      code_n    = code;
`endif
      case (state)
         ST_LOCKED: begin
            if (is_dig) begin
               sftreg_n = shifted;
               ndig_n   = ndig_inc;
            end else if (is_star || is_hash) begin
               sftreg_n = '0;
               ndig_n   = 4'd0;
               timer_n  = '0;
               if (is_hash) begin
                  if (match)         failcnt_n = 2'd0;
                  else if (fail_max) failcnt_n = 2'(MAX_FAIL);
                  else               failcnt_n = failcnt + 2'd1;
               end
            end
         end
         ST_OPEN: begin
            if (open_exp || is_star) begin
               sftreg_n = '0;
               ndig_n   = 4'd0;
               timer_n  = '0;
            end else if (is_dig) begin
               sftreg_n = shifted;
               ndig_n   = ndig_inc;
               timer_n  = '0;
            end else begin
               if (tick) timer_n = timer + TW'(1);
`ifdef CODE_CHANGE_EN
               if (is_hash) begin
                  sftreg_n = '0;
                  ndig_n   = 4'd0;
                  if (full) begin
                     code_n  = sftreg;
                     timer_n = '0;
                  end
               end
`endif
            end
         end
         ST_ALARM: begin
            if (alarm_exp) begin
               timer_n   = '0;
               failcnt_n = 2'd0;
            end else if (tick) begin
               timer_n = timer + TW'(1);
            end
         end
         default: begin
            sftreg_n  = '0;
            ndig_n    = 4'd0;
            failcnt_n = 2'd0;
            timer_n   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl with hand-computed expectations.
// Exercises the CODE_CHANGE_EN variant when that macro is defined.
module tb_lock_ctrl;

   logic        ck;
   logic        resetn;
   logic        tick;
   logic [3:0]  keycode;
   logic        keyenbl;
   logic [15:0] sftreg;
   logic [3:0]  ndig;
   logic        unlock;
   logic        alarm;
   logic [1:0]  failcnt;

   int checks = 0;
   int errors = 0;

   lock_ctrl dut (
      .ck      (ck),
      .resetn  (resetn),
      .tick    (tick),
      .keycode (keycode),
      .keyenbl (keyenbl),
      .sftreg  (sftreg),
      .ndig    (ndig),
      .unlock  (unlock),
      .alarm   (alarm),
      .failcnt (failcnt)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic press(input logic [3:0] k);
      @(negedge ck);
      keycode = k;
      keyenbl = 1'b1;
      repeat (3) @(negedge ck);
      keyenbl = 1'b0;
      @(negedge ck);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge ck);
         tick = 1'b1;
         @(negedge ck);
         tick = 1'b0;
      end
   endtask

   task automatic enter_code(input logic [15:0] c);
      logic [15:0] v;
      v = c;
      for (int i = 3; i >= 0; i--) press(v[i*4 +: 4]);
      press(4'hB);
   endtask

   task automatic test_reset;
      resetn = 1'b0; tick = 1'b0; keycode = 4'h0; keyenbl = 1'b0;
      repeat (3) @(negedge ck);
      checks++;
      if ({sftreg, ndig, unlock, alarm, failcnt} !== 24'h0) begin
         errors++;
         $display("FAIL reset_outputs got %h exp 000000", {sftreg, ndig, unlock, alarm, failcnt});
      end
      resetn = 1'b1;
      @(negedge ck);
   endtask

   task automatic test_unlock;
      for (int i = 1; i <= 4; i++) press(4'(i));
      checks++;
      if (sftreg !== 16'h1234 || ndig !== 4'd4) begin
         errors++;
         $display("FAIL entry_1234 got %h/%0d exp 1234/4", sftreg, ndig);
      end
      @(negedge ck);
      keycode = 4'hB; keyenbl = 1'b1;
      @(negedge ck);
      checks++;
      if (unlock !== 1'b0) begin
         errors++;
         $display("FAIL unlock_early got %b exp 0", unlock);
      end
      @(negedge ck);
      checks++;
      if (unlock !== 1'b1 || failcnt !== 2'd0 || sftreg !== 16'h0 || ndig !== 4'd0) begin
         errors++;
         $display("FAIL unlock_2ck got u=%b f=%0d s=%h n=%0d exp u=1 f=0 s=0000 n=0",
                  unlock, failcnt, sftreg, ndig);
      end
      keyenbl = 1'b0;
      @(negedge ck);
      press(4'hA);
      checks++;
      if (unlock !== 1'b0) begin
         errors++;
         $display("FAIL star_relock got %b exp 0", unlock);
      end
   endtask

   task automatic test_timeout;
      enter_code(16'h1234);
      ticks(159);
      checks++;
      if (unlock !== 1'b1) begin
         errors++;
         $display("FAIL open_159 got %b exp 1", unlock);
      end
      ticks(1);
      checks++;
      if (unlock !== 1'b0) begin
         errors++;
         $display("FAIL open_160 got %b exp 0", unlock);
      end
      enter_code(16'h1234);
      ticks(10);
      press(4'hA);
      checks++;
      if (unlock !== 1'b0) begin
         errors++;
         $display("FAIL star_tick10 got %b exp 0", unlock);
      end
      // a digit while open restarts the relock timer
      enter_code(16'h1234);
      ticks(150);
      press(4'h5);
      ticks(159);
      checks++;
      if (unlock !== 1'b1) begin
         errors++;
         $display("FAIL digit_restart got %b exp 1", unlock);
      end
      ticks(1);
      checks++;
      if (unlock !== 1'b0) begin
         errors++;
         $display("FAIL digit_restart_exp got %b exp 0", unlock);
      end
   endtask

   task automatic test_simultaneous;
      enter_code(16'h1234);
      ticks(159);
      @(negedge ck);
      keycode = 4'h7; keyenbl = 1'b1;
      @(negedge ck);
      tick = 1'b1;
      @(negedge ck);
      tick = 1'b0;
      checks++;
      if (unlock !== 1'b0 || ndig !== 4'd0) begin
         errors++;
         $display("FAIL key_vs_expire got u=%b n=%0d exp u=0 n=0", unlock, ndig);
      end
      keyenbl = 1'b0;
      repeat (2) @(negedge ck);
   endtask

   task automatic test_alarm;
      for (int r = 1; r <= 3; r++) begin
         enter_code(16'h1235);
         checks++;
         if (failcnt !== 2'(r) || alarm !== (r == 3)) begin
            errors++;
            $display("FAIL wrong_code_%0d got f=%0d a=%b exp f=%0d a=%b",
                     r, failcnt, alarm, r, (r == 3));
         end
      end
      enter_code(16'h1234);
      press(4'h8);
      checks++;
      if (unlock !== 1'b0 || ndig !== 4'd0 || alarm !== 1'b1) begin
         errors++;
         $display("FAIL alarm_keys got u=%b n=%0d a=%b exp u=0 n=0 a=1", unlock, ndig, alarm);
      end
      ticks(319);
      checks++;
      if (alarm !== 1'b1 || failcnt !== 2'd3) begin
         errors++;
         $display("FAIL alarm_319 got a=%b f=%0d exp a=1 f=3", alarm, failcnt);
      end
      ticks(1);
      checks++;
      if (alarm !== 1'b0 || failcnt !== 2'd0) begin
         errors++;
         $display("FAIL alarm_320 got a=%b f=%0d exp a=0 f=0", alarm, failcnt);
      end
   endtask

   task automatic test_shift;
      press(4'h9);
      enter_code(16'h1234);
      checks++;
      if (unlock !== 1'b1) begin
         errors++;
         $display("FAIL five_digits got %b exp 1", unlock);
      end
      press(4'hA);
      press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'h4); press(4'hB);
      checks++;
      if (failcnt !== 2'd1 || unlock !== 1'b0) begin
         errors++;
         $display("FAIL star_clear got f=%0d u=%b exp f=1 u=0", failcnt, unlock);
      end
      press(4'hC); press(4'hF);
      checks++;
      if (ndig !== 4'd0 || sftreg !== 16'h0 || failcnt !== 2'd1) begin
         errors++;
         $display("FAIL ignored_keys got n=%0d s=%h f=%0d exp n=0 s=0000 f=1", ndig, sftreg, failcnt);
      end
      enter_code(16'h1234);
      checks++;
      if (failcnt !== 2'd0 || unlock !== 1'b1) begin
         errors++;
         $display("FAIL fail_clear got f=%0d u=%b exp f=0 u=1", failcnt, unlock);
      end
      press(4'hA);
   endtask

   task automatic test_hold_reset;
      @(negedge ck);
      keycode = 4'h7; keyenbl = 1'b1;
      repeat (100) @(negedge ck);
      keyenbl = 1'b0;
      @(negedge ck);
      checks++;
      if (ndig !== 4'd1 || sftreg !== 16'h0007) begin
         errors++;
         $display("FAIL hold_key got n=%0d s=%h exp n=1 s=0007", ndig, sftreg);
      end
      press(4'h1);
      @(negedge ck);
      #2 resetn = 1'b0;
      #1;
      checks++;
      if ({sftreg, ndig, unlock, alarm, failcnt} !== 24'h0) begin
         errors++;
         $display("FAIL async_reset got %h exp 000000", {sftreg, ndig, unlock, alarm, failcnt});
      end
      keycode = 4'h5; keyenbl = 1'b1;
      @(negedge ck);
      resetn = 1'b1;
      repeat (5) @(negedge ck);
      checks++;
      if (ndig !== 4'd0) begin
         errors++;
         $display("FAIL held_over_reset got %0d exp 0", ndig);
      end
      keyenbl = 1'b0;
      @(negedge ck);
      press(4'h5);
      checks++;
      if (ndig !== 4'd1 || sftreg !== 16'h0005) begin
         errors++;
         $display("FAIL repress got n=%0d s=%h exp n=1 s=0005", ndig, sftreg);
      end
      press(4'hA);
   endtask

   task automatic test_code_change;
      enter_code(16'h1234);
      enter_code(16'h5678);
`ifdef CODE_CHANGE_EN
      checks++;
      if (unlock !== 1'b1 || ndig !== 4'd0) begin
         errors++;
         $display("FAIL code_load got u=%b n=%0d exp u=1 n=0", unlock, ndig);
      end
      press(4'hA);
      enter_code(16'h5678);
      checks++;
      if (unlock !== 1'b1) begin
         errors++;
         $display("FAIL new_code got %b exp 1", unlock);
      end
      press(4'hA);
      enter_code(16'h1234);
      checks++;
      if (unlock !== 1'b0 || failcnt !== 2'd1) begin
         errors++;
         $display("FAIL old_code got u=%b f=%0d exp u=0 f=1", unlock, failcnt);
      end
`else
      checks++;
      if (unlock !== 1'b1 || ndig !== 4'd4 || sftreg !== 16'h5678) begin
         errors++;
         $display("FAIL hash_open got u=%b n=%0d s=%h exp u=1 n=4 s=5678", unlock, ndig, sftreg);
      end
      press(4'hA);
      enter_code(16'h5678);
      checks++;
      if (unlock !== 1'b0 || failcnt !== 2'd1) begin
         errors++;
         $display("FAIL fixed_code got u=%b f=%0d exp u=0 f=1", unlock, failcnt);
      end
      enter_code(16'h1234);
      checks++;
      if (unlock !== 1'b1) begin
         errors++;
         $display("FAIL init_code got %b exp 1", unlock);
      end
`endif
      press(4'hA);
   endtask

   initial begin
      test_reset;
      test_unlock;
      test_timeout;
      test_simultaneous;
      test_alarm;
      test_shift;
      test_hold_reset;
      test_code_change;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lock_ctrl.md
Name: lock_ctrl

Overview:
Consumer end of the keypad path. Takes the debounced keycode/keyenbl stream produced by the keypad input block and assembles a DIGITS-long entry, and '#' submits it for comparison against the stored code. Drives the lock actuator, the entry display register and the alarm. Sits between top_input and the actuator/display drivers in the electronic lock top level.

Parameters:
DIGITS, 4, number of BCD digits in the code (1..8)
INIT_CODE, 16'h1234, code loaded at reset (BCD, DIGITS*4 bits)
OPEN_TICKS, 160, tick count before auto-relock (5 s at 32 Hz)
MAX_FAIL, 3, consecutive wrong submissions that trigger alarm
ALARM_TICKS, 320, tick count alarm stays asserted (10 s at 32 Hz)

Ports:
ck  in  1  system clock
resetn  in  1  asynchronous active-low reset
tick  in  1  one-ck-wide timing strobe (hz32 from the input block)
keycode  in  4  key value: 0-9 digit, 4'hA '*', 4'hB '#', 4'hC-F ignored
keyenbl  in  1  high while a debounced key is held; keycode valid while high
sftreg  out  DIGITS*4  entry register, newest digit in [3:0]
ndig  out  4  digits currently entered (0..DIGITS)
unlock  out  1  1 = actuator released
alarm  out  1  1 = alarm sounding
failcnt  out  2  consecutive failures (saturates at MAX_FAIL)

Behaviour:
- Clock: ck only. Reset: asynchronous, active-low (resetn); all state returns immediately.
- Reset values: sftreg=0, ndig=0, unlock=0, alarm=0, failcnt=0, state=LOCKED, code=INIT_CODE, timer=0.
- Key event: rising edge of keyenbl, registered internally, so that one press gives exactly one event (kev), one ck after the edge. keycode is sampled on the same ck as the edge. Holding a key gives no repeats.
- The event is processed on the ck after kev. Total latency from the keyenbl edge to an output change is 2 ck.
- States: LOCKED, OPEN, ALARM.
- LOCKED:
  - Digit: sftreg <= {sftreg[DIGITS*4-5:0], keycode}. ndig increments, saturating at DIGITS. Once saturated, further digits still shift, so the oldest digit is lost.
  - '*': sftreg=0, ndig=0.
  - '#' with ndig==DIGITS and sftreg==code: go to OPEN, unlock=1, failcnt=0, clear the entry, timer=0.
  - '#' with a wrong entry or ndig<DIGITS: failcnt+1, clear the entry. If failcnt reaches MAX_FAIL, go to ALARM, alarm=1, timer=0.
- OPEN:
  - Timer increments on each tick. At timer==OPEN_TICKS-1 with tick, go to LOCKED, unlock=0.
  - '*': relock immediately.
  - Digits are entered as in LOCKED, and each digit resets timer to 0. '#' is ignored unless CODE_CHANGE_EN is defined.
- ALARM:
  - All keys are ignored.
  - Timer counts ticks. At ALARM_TICKS-1, go to LOCKED, alarm=0, failcnt=0.
- Simultaneous kev and expiring tick: the timeout wins and the key event is discarded.
- keycode 4'hC-F: no effect in any state.
- keyenbl held across a reset release: no event until keyenbl falls and rises again. The edge register resets to 1.

Optional Feature:
CODE_CHANGE_EN:
- Defined: in OPEN, '#' with ndig==DIGITS loads code<=sftreg, clears the entry, and stays OPEN with timer reset. '#' with ndig<DIGITS clears the entry only.
- Undefined: the code is fixed at INIT_CODE, '#' is ignored in OPEN, and the code register reduces to a constant.

Decomposition:
- Package lock_pkg holds:
  - state encoding constants ST_LOCKED=2'd0, ST_OPEN=2'd1, ST_ALARM=2'd2
  - key constants KEY_STAR=4'hA, KEY_HASH=4'hB
  - width function/constant for timer width, derived from max(OPEN_TICKS, ALARM_TICKS)
- One sub-module is natural: key_edge, the keyenbl rising-edge detector that produces kev and the captured keycode.

Test Plan:
- Reset, then press 1,2,3,4,'#' -> unlock=1 2 ck after the '#' edge, failcnt=0, sftreg=0, ndig=0.
- Press 1,2,3,5,'#' three times -> failcnt 1,2,3. alarm=1 after the third. Keys are ignored while alarmed. alarm=0 and failcnt=0 after 320 ticks.
- After unlock, no keys for 160 ticks -> unlock=0 exactly on the 160th tick. Repeat with '*' at tick 10 -> immediate relock.
- Press 9,1,2,3,4,'#' -> unlock=1 (oldest digit shifted out). Press 1,2,'*',3,4,'#' -> failcnt=1.
- Hold keyenbl high 100 ck on digit 7 -> ndig=1 only. Assert resetn=0 mid-entry -> all outputs return to reset values immediately.
- With CODE_CHANGE_EN: unlock, press 5,6,7,8,'#', then '*', then 5,6,7,8,'#' -> unlock=1, and 1,2,3,4,'#' now fails.
